// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath widths and the reorder-buffer entry record.
package tomasulo_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_W     = 4;
    localparam int ROB_DEPTH = 4;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit stage: entries are allocated at dispatch, completed by CDB
// broadcasts and retired from the head one per cycle; a read port forwards results.
module reorder_buffer
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_alloc_valid,
    input  logic [REG_W-1:0]  i_alloc_dest,
    output logic              o_alloc_ready,
    output logic [TAG_W-1:0]  o_alloc_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic [TAG_W-1:0]  i_read_tag,
    output logic              o_read_ready,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_commit_valid,
    output logic [REG_W-1:0]  o_commit_dest,
    output logic [DATA_W-1:0] o_commit_data,
    output logic [TAG_W-1:0]  o_commit_tag,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [TAG_W:0]    o_count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    rob_entry_t        r_entries [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    logic              r_commit_valid;
    logic [REG_W-1:0]  r_commit_dest;
    logic [DATA_W-1:0] r_commit_data;
    logic [TAG_W-1:0]  r_commit_tag;

    rob_entry_t        w_head_entry;
    rob_entry_t        w_read_entry;
    logic              w_full;
    logic              w_alloc;
    logic              w_commit;
    logic              w_cdb_hit;

    assign w_full       = (r_count == FULL_COUNT);
    assign w_alloc      = i_alloc_valid && !w_full;
    assign w_head_entry = r_entries[r_head];
    assign w_commit     = w_head_entry.busy && w_head_entry.ready;
    assign w_cdb_hit    = i_cdb_valid && r_entries[i_cdb_tag].busy;
    assign w_read_entry = r_entries[i_read_tag];

    // Allocation is applied last so it overrides a CDB write to the same slot.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_dest  <= '0;
            r_commit_data  <= '0;
            r_commit_tag   <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].busy  <= 1'b0;
                r_entries[i].ready <= 1'b0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
        end else begin
            if (w_cdb_hit) begin
                r_entries[i_cdb_tag].ready <= 1'b1;
                r_entries[i_cdb_tag].value <= i_cdb_data;
            end
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_dest           <= w_head_entry.dest;
                r_commit_data           <= w_head_entry.value;
                r_commit_tag            <= r_head;
                r_entries[r_head].busy  <= 1'b0;
                r_entries[r_head].ready <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_entries[r_tail].busy  <= 1'b1;
                r_entries[r_tail].ready <= 1'b0;
                r_entries[r_tail].dest  <= i_alloc_dest;
                r_tail                  <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_alloc_ready  = !w_full;
    assign o_alloc_tag    = r_tail;
    assign o_full         = w_full;
    assign o_empty        = (r_count == '0);
    assign o_count        = r_count;
    assign o_read_ready   = w_read_entry.busy && w_read_entry.ready;
    assign o_read_data    = o_read_ready ? w_read_entry.value : '0;
    assign o_commit_valid = r_commit_valid;
    assign o_commit_dest  = r_commit_dest;
    assign o_commit_data  = r_commit_data;
    assign o_commit_tag   = r_commit_tag;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by random
// traffic, compared every cycle against a program-order queue model.
module tb_reorder_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        allocValid;
    logic [3:0]  allocDest;
    logic        allocReady;
    logic [1:0]  allocTag;
    logic        cdbValid;
    logic [1:0]  cdbTag;
    logic [15:0] cdbData;
    logic [1:0]  readTag;
    logic        readReady;
    logic [15:0] readData;
    logic        commitValid;
    logic [3:0]  commitDest;
    logic [15:0] commitData;
    logic [1:0]  commitTag;
    logic        flush;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    int testsRun    = 0;
    int testsFailed = 0;

    reorder_buffer dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_alloc_valid  (allocValid),
        .i_alloc_dest   (allocDest),
        .o_alloc_ready  (allocReady),
        .o_alloc_tag    (allocTag),
        .i_cdb_valid    (cdbValid),
        .i_cdb_tag      (cdbTag),
        .i_cdb_data     (cdbData),
        .i_read_tag     (readTag),
        .o_read_ready   (readReady),
        .o_read_data    (readData),
        .o_commit_valid (commitValid),
        .o_commit_dest  (commitDest),
        .o_commit_data  (commitData),
        .o_commit_tag   (commitTag),
        .i_flush        (flush),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count)
    );

    always #5 clock = ~clock;

    // Reference model: instructions in program order, oldest at the front.
    typedef struct {
        int tag;
        int dest;
        bit rdy;
        int value;
    } mEntry;

    mEntry mQueue[$];
    int    mTail   = 0;
    bit    mCv     = 0;
    int    mCdest  = 0;
    int    mCdata  = 0;
    int    mCtag   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int findTag(input int t);
        for (int i = 0; i < mQueue.size(); i++) begin
            if (mQueue[i].tag == t) return i;
        end
        return -1;
    endfunction

    // Drives one cycle of inputs, checks outputs against the model, then advances the model.
    task automatic applyStimulus(input bit doCheck, input bit rst, input bit fl,
                                 input bit av, input int ad, input bit cv,
                                 input int ct, input int cd, input int rt);
        int  rIdx;
        int  cIdx;
        bit  mFull;
        bit  mAlloc;
        bit  mCommit;
        int  expReadData;
        bit  expReadReady;
        @(negedge clock);
        reset      = rst;
        flush      = fl;
        allocValid = av;
        allocDest  = 4'(ad);
        cdbValid   = cv;
        cdbTag     = 2'(ct);
        cdbData    = 16'(cd);
        readTag    = 2'(rt);
        #1;
        mFull = (mQueue.size() == DEPTH);
        rIdx  = findTag(rt);
        expReadReady = (rIdx >= 0) && mQueue[rIdx].rdy;
        expReadData  = expReadReady ? mQueue[rIdx].value : 0;
        if (doCheck) begin
            checkOutput("alloc_ready",  32'(allocReady),  32'(!mFull));
            checkOutput("alloc_tag",    32'(allocTag),    32'(mTail));
            checkOutput("count",        32'(count),       32'(mQueue.size()));
            checkOutput("full",         32'(full),        32'(mFull));
            checkOutput("empty",        32'(empty),       32'(mQueue.size() == 0));
            checkOutput("commit_valid", 32'(commitValid), 32'(mCv));
            checkOutput("commit_dest",  32'(commitDest),  32'(mCdest));
            checkOutput("commit_data",  32'(commitData),  32'(mCdata));
            checkOutput("commit_tag",   32'(commitTag),   32'(mCtag));
            checkOutput("read_ready",   32'(readReady),   32'(expReadReady));
            checkOutput("read_data",    32'(readData),    32'(expReadData));
        end
        if (rst) begin
            mQueue.delete();
            mTail  = 0;
            mCv    = 0;
            mCdest = 0;
            mCdata = 0;
            mCtag  = 0;
        end else if (fl) begin
            mQueue.delete();
            mTail = 0;
            mCv   = 0;
        end else begin
            mAlloc  = av && !mFull;
            mCommit = (mQueue.size() > 0) && mQueue[0].rdy;
            mCv     = mCommit;
            if (mCommit) begin
                mCdest = mQueue[0].dest;
                mCdata = mQueue[0].value;
                mCtag  = mQueue[0].tag;
                void'(mQueue.pop_front());
            end
            if (cv) begin
                cIdx = findTag(ct);
                if (cIdx >= 0) begin
                    mQueue[cIdx].rdy   = 1;
                    mQueue[cIdx].value = cd & 16'hFFFF;
                end
            end
            if (mAlloc) begin
                mQueue.push_back('{tag: mTail, dest: ad & 4'hF, rdy: 0, value: 0});
                mTail = (mTail + 1) % DEPTH;
            end
        end
        @(posedge clock);
    endtask

    task automatic idle(input int rt);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, rt);
    endtask

    task automatic doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pick;
        int ct;
        bit cv;

        $display("[TB] reset");
        doReset();
        idle(0);

        $display("[TB] out-of-order completion");
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 30, 2);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 10, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 20, 1);
        for (int i = 0; i < 4; i++) idle(i);

        $display("[TB] full and wrap");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, i + 4, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 9, 1, 0, 16'h0055, 0);
        applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 10, 0, 0, 0, 0);
        idle(0);

        $display("[TB] forwarding");
        doReset();
        applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 6, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 16'h00AB, 1);
        idle(1);
        idle(3);

        $display("[TB] flush mid-run");
        applyStimulus(1, 0, 0, 1, 7, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 8, 1, 0, 16'h1234, 0);
        idle(0);

        $display("[TB] stray cdb");
        applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 16'hBEEF, 2);
        idle(2);
        idle(0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 99));
            cv   = ($urandom_range(0, 99) < 50);
            if (mQueue.size() > 0 && $urandom_range(0, 99) < 85)
                ct = mQueue[$urandom_range(0, mQueue.size() - 1)].tag;
            else
                ct = int'($urandom_range(0, DEPTH - 1));
            applyStimulus(1, pick == 0, (pick >= 1 && pick <= 3),
                          ($urandom_range(0, 99) < 60), int'($urandom_range(0, 15)),
                          cv, ct, int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, DEPTH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
